// File: rtl/ticket_store_ram.sv
// ticket_store_ram: slot-based ticket record store with id assignment, by-id access and by-index lookup.
// Optional build macro TICKET_STORE_FULL_EN adds w_ram_ticket_full_o and fast-fails new when full.
module ticket_store_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 65
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    r_ram_ticket_operation_i,
    input  logic [31:0]   r_ram_ticket_index_i,
    input  logic [5:0]    r_ram_ticket_id_i,
    input  logic [DW-1:0] r_ram_ticket_data_i,
    output logic          w_ram_ticket_over_o,
    output logic          w_ram_ticket_wrong_o,
    output logic [31:0]   w_ram_ticket_num_o,
    output logic [5:0]    w_ram_ticket_id_o,
    output logic [DW-1:0] w_ram_ticket_data_o
`ifdef TICKET_STORE_FULL_EN
    ,
    output logic          w_ram_ticket_full_o
`endif
);
    localparam int unsigned IDW = 6;
    localparam int unsigned PW  = DW - IDW;
    localparam int unsigned AW  = $clog2(DEPTH);

    localparam logic [2:0] OP_IDLE     = 3'b000;
    localparam logic [2:0] OP_NEW      = 3'b001;
    localparam logic [2:0] OP_READ_ID  = 3'b010;
    localparam logic [2:0] OP_CHANGE   = 3'b011;
    localparam logic [2:0] OP_DELETE   = 3'b100;
    localparam logic [2:0] OP_READ_IDX = 3'b101;
    localparam logic [2:0] OP_CLEAR    = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DIRECT, S_CLEAR, S_DONE} state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [31:0]         r_index;
    logic [IDW-1:0]      r_id;
    logic [PW-1:0]       r_data;
    logic [AW-1:0]       r_ptr;
    logic [31:0]         r_cnt;
    logic [DEPTH-1:0]    r_valid;
    logic [DW-1:0]       r_mem [DEPTH];
    logic                r_over;
    logic                r_wrong;
    logic [31:0]         r_num;
    logic [IDW-1:0]      r_id_o;
    logic [DW-1:0]       r_data_o;

    logic [AW-1:0]       w_id_slot;
    logic                w_id_ok;
    logic                w_last;
    logic                w_idx_hit;
    logic [31:0]         w_num_nxt;
    logic                w_wr_en;
    logic [AW-1:0]       w_wr_addr;
    logic [DW-1:0]       w_wr_data;
    logic                w_unused_id_bits;

    // Incoming id bits are always replaced by the store, so they are never consumed.
    assign w_unused_id_bits = ^r_ram_ticket_data_i[DW-1:PW];

    assign w_id_slot = AW'(r_id - IDW'(1));
    assign w_id_ok   = (r_id != '0) && (r_id <= IDW'(DEPTH)) && r_valid[w_id_slot];
    assign w_last    = (r_ptr == AW'(DEPTH - 1));
    assign w_idx_hit = r_valid[r_ptr] && ((r_cnt + 32'd1) == r_index);

    // Live count and record write port follow the state being executed this cycle.
    always_comb begin
        w_num_nxt = r_num;
        w_wr_en   = 1'b0;
        w_wr_addr = r_ptr;
        w_wr_data = {IDW'(r_ptr) + IDW'(1), r_data};
        case (r_state)
            S_DIRECT: begin
                if (r_op == OP_DELETE && w_id_ok) begin
                    w_num_nxt = r_num - 32'd1;
                end
                if (r_op == OP_CHANGE && w_id_ok) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_id_slot;
                    w_wr_data = {r_mem[w_id_slot][DW-1:PW], r_data};
                end
            end
            S_SCAN: begin
                if (r_op == OP_NEW && !r_valid[r_ptr]) begin
                    w_num_nxt = r_num + 32'd1;
                    w_wr_en   = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_last) begin
                    w_num_nxt = '0;
                end else if (r_valid[r_ptr]) begin
                    w_num_nxt = r_num - 32'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_IDLE;
            r_index  <= '0;
            r_id     <= '0;
            r_data   <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_valid  <= '0;
            r_over   <= 1'b0;
            r_wrong  <= 1'b0;
            r_num    <= '0;
            r_id_o   <= '0;
            r_data_o <= '0;
        end else begin
            r_num <= w_num_nxt;
            case (r_state)
                S_IDLE: begin
                    if (r_ram_ticket_operation_i != OP_IDLE) begin
                        r_op    <= r_ram_ticket_operation_i;
                        r_index <= r_ram_ticket_index_i;
                        r_id    <= r_ram_ticket_id_i;
                        r_data  <= r_ram_ticket_data_i[PW-1:0];
                        r_ptr   <= '0;
                        r_cnt   <= '0;
                        case (r_ram_ticket_operation_i)
`ifdef TICKET_STORE_FULL_EN
                            OP_NEW:      r_state <= (r_num == 32'(DEPTH)) ? S_DIRECT : S_SCAN;
`else
                            OP_NEW:      r_state <= S_SCAN;
`endif
                            OP_READ_IDX: r_state <= (r_ram_ticket_index_i == '0 ||
                                                     r_ram_ticket_index_i > r_num) ? S_DIRECT : S_SCAN;
                            OP_CLEAR:    r_state <= S_CLEAR;
                            default:     r_state <= S_DIRECT;
                        endcase
                    end
                end
                // Single-cycle ops; anything not listed here (reserved, bad index, full new) fails.
                S_DIRECT: begin
                    r_state <= S_DONE;
                    r_over  <= 1'b1;
                    r_wrong <= 1'b1;
                    if (w_id_ok) begin
                        case (r_op)
                            OP_READ_ID: begin
                                r_wrong  <= 1'b0;
                                r_data_o <= r_mem[w_id_slot];
                            end
                            OP_CHANGE: r_wrong <= 1'b0;
                            OP_DELETE: begin
                                r_wrong            <= 1'b0;
                                r_valid[w_id_slot] <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_SCAN: begin
                    if (r_op == OP_NEW ? !r_valid[r_ptr] : w_idx_hit) begin
                        r_state <= S_DONE;
                        r_over  <= 1'b1;
                        r_wrong <= 1'b0;
                        r_id_o  <= IDW'(r_ptr) + IDW'(1);
                        if (r_op == OP_NEW) begin
                            r_valid[r_ptr] <= 1'b1;
                        end else begin
                            r_data_o <= r_mem[r_ptr];
                        end
                    end else if (w_last) begin
                        r_state <= S_DONE;
                        r_over  <= 1'b1;
                        r_wrong <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + AW'(1);
                        if (r_valid[r_ptr]) begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_valid[r_ptr] <= 1'b0;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_over  <= 1'b1;
                        r_wrong <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
                S_DONE: begin
                    if (r_ram_ticket_operation_i == OP_IDLE) begin
                        r_over  <= 1'b0;
                        r_wrong <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TICKET_STORE_FULL_EN
    logic r_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else begin
            r_full <= (w_num_nxt == 32'(DEPTH));
        end
    end

    assign w_ram_ticket_full_o = r_full;
`endif

    assign w_ram_ticket_over_o  = r_over;
    assign w_ram_ticket_wrong_o = r_wrong;
    assign w_ram_ticket_num_o   = r_num;
    assign w_ram_ticket_id_o    = r_id_o;
    assign w_ram_ticket_data_o  = r_data_o;

endmodule

// File: tb/tb_ticket_store_ram.sv
// Bench for ticket_store_ram: directed scenarios plus randomized ops against a slot-array model.
module tb_ticket_store_ram;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] idx_i = '0;
    logic [5:0]  id_i = '0;
    logic [64:0] data_i = '0;
    logic        over;
    logic        wrong;
    logic [31:0] num;
    logic [5:0]  id_o;
    logic [64:0] data_o;
    logic        full_o;

    ticket_store_ram #(.DEPTH(DEPTH), .DW(65)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .r_ram_ticket_operation_i (op_i),
        .r_ram_ticket_index_i     (idx_i),
        .r_ram_ticket_id_i        (id_i),
        .r_ram_ticket_data_i      (data_i),
        .w_ram_ticket_over_o      (over),
        .w_ram_ticket_wrong_o     (wrong),
        .w_ram_ticket_num_o       (num),
        .w_ram_ticket_id_o        (id_o),
        .w_ram_ticket_data_o      (data_o)
`ifdef TICKET_STORE_FULL_EN
        ,
        .w_ram_ticket_full_o      (full_o)
`endif
    );

`ifndef TICKET_STORE_FULL_EN
    assign full_o = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain array of records and valid flags.
    logic [64:0] m_mem [DEPTH];
    bit          m_val [DEPTH];
    int          m_cnt = 0;
    logic [5:0]  m_id_o = '0;
    logic [64:0] m_data_o = '0;
    int          e_lat;
    bit          e_wrong;

    // Snapshot at completion and one edge after release.
    int          s_lat;
    logic        s_wrong, s_over_after, s_wrong_after;
    logic [5:0]  s_id;
    logic [64:0] s_data;
    logic [31:0] s_num;

    function automatic bit m_id_ok(input logic [5:0] id);
        return (id >= 1) && (id <= 6'(DEPTH)) && m_val[id - 6'd1];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
        m_cnt = 0; m_id_o = '0; m_data_o = '0;
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [31:0] idx,
                               input logic [5:0] id, input logic [64:0] d);
        int s;
        int k;
        e_wrong = 0;
        e_lat = 1;
        s = -1;
        case (op)
            3'b001: begin
                for (int i = 0; i < DEPTH; i++) if (!m_val[i] && s < 0) s = i;
                if (s < 0) begin
                    e_wrong = 1;
`ifdef TICKET_STORE_FULL_EN
                    e_lat = 1;
`else
                    e_lat = DEPTH;
`endif
                end else begin
                    m_val[s] = 1;
                    m_mem[s] = {6'(s + 1), d[58:0]};
                    m_cnt++;
                    m_id_o = 6'(s + 1);
                    e_lat = s + 1;
                end
            end
            3'b010: if (m_id_ok(id)) m_data_o = m_mem[id - 6'd1]; else e_wrong = 1;
            3'b011: if (m_id_ok(id)) m_mem[id - 6'd1][58:0] = d[58:0]; else e_wrong = 1;
            3'b100: if (m_id_ok(id)) begin m_val[id - 6'd1] = 0; m_cnt--; end else e_wrong = 1;
            3'b101: begin
                if (idx == 0 || idx > 32'(m_cnt)) e_wrong = 1;
                else begin
                    k = 0;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (m_val[i]) begin
                            k++;
                            if (32'(k) == idx && s < 0) s = i;
                        end
                    end
                    e_lat = s + 1;
                    m_id_o = 6'(s + 1);
                    m_data_o = m_mem[s];
                end
            end
            3'b111: begin
                for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
                m_cnt = 0;
                e_lat = DEPTH;
            end
            default: e_wrong = 1;
        endcase
    endtask

    // Issue one request, scramble inputs while busy, wait for over, then return to idle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] idx,
                          input logic [5:0] id, input logic [64:0] d);
        op_i = op; idx_i = idx; id_i = id; data_i = d;
        model_apply(op, idx, id, d);
        @(posedge clk); #1;
        idx_i = $urandom; id_i = 6'($urandom); data_i = 65'({$urandom, $urandom, $urandom});
        s_lat = 0;
        do begin
            @(posedge clk); #1;
            s_lat++;
        end while (!over && s_lat < 4 * DEPTH);
        if (!over) begin
            n_cmp++; n_err++;
            $display("FAIL timeout op=%0d: over never rose within %0d cycles", op, s_lat);
        end
        s_wrong = wrong; s_id = id_o; s_data = data_o; s_num = num;
        op_i = '0;
        @(posedge clk); #1;
        s_over_after = over; s_wrong_after = wrong;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({over, wrong, num, id_o, data_o, full_o} !== '0) begin n_err++;
            $display("FAIL reset_outputs got over=%b wrong=%b num=%0d id=%0d data=%h full=%b exp all 0",
                     over, wrong, num, id_o, data_o, full_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({over, num} !== '0) begin n_err++;
            $display("FAIL reset_release got over=%b num=%0d exp 0", over, num); end
        model_reset();
    endtask

    task automatic test_new_read_delete();
        for (int k = 1; k <= 3; k++) begin
            run_op(3'b001, 0, 0, '0);
            n_cmp++; if (s_lat !== k || s_wrong !== 1'b0 || s_id !== 6'(k)) begin n_err++;
                $display("FAIL new%0d got lat=%0d wrong=%b id=%0d exp lat=%0d wrong=0 id=%0d",
                         k, s_lat, s_wrong, s_id, k, k); end
        end
        n_cmp++; if (s_num !== 32'd3) begin n_err++;
            $display("FAIL num_after_3new got %0d exp 3", s_num); end
        for (int k = 1; k <= 3; k++) begin
            run_op(3'b010, 0, 6'(k), '0);
            n_cmp++; if (s_lat !== 1 || s_wrong !== 1'b0 || s_data !== {6'(k), 59'd0}) begin n_err++;
                $display("FAIL read_id%0d got lat=%0d wrong=%b data=%h exp lat=1 wrong=0 data=%h",
                         k, s_lat, s_wrong, s_data, {6'(k), 59'd0}); end
        end
        run_op(3'b100, 0, 6'd2, '0);
        n_cmp++; if (s_wrong !== 1'b0 || s_num !== 32'd2) begin n_err++;
            $display("FAIL delete2 got wrong=%b num=%0d exp wrong=0 num=2", s_wrong, s_num); end
        run_op(3'b101, 32'd2, 0, '0);
        n_cmp++; if (s_lat !== 3 || s_id !== 6'd3 || s_wrong !== 1'b0) begin n_err++;
            $display("FAIL read_idx2 got lat=%0d id=%0d wrong=%b exp lat=3 id=3 wrong=0",
                     s_lat, s_id, s_wrong); end
        run_op(3'b101, 32'd3, 0, '0);
        n_cmp++; if (s_lat !== 1 || s_wrong !== 1'b1 || s_id !== 6'd3) begin n_err++;
            $display("FAIL read_idx3 got lat=%0d wrong=%b id=%0d exp lat=1 wrong=1 id=3",
                     s_lat, s_wrong, s_id); end
        run_op(3'b110, 0, 0, '0);
        n_cmp++; if (s_lat !== 1 || s_wrong !== 1'b1 || s_over_after !== 1'b0) begin n_err++;
            $display("FAIL reserved got lat=%0d wrong=%b over_after=%b exp lat=1 wrong=1 over_after=0",
                     s_lat, s_wrong, s_over_after); end
    endtask

    task automatic test_hold_done();
        op_i = 3'b010; id_i = 6'd9;
        model_apply(3'b010, 0, 6'd9, '0);
        @(posedge clk);
        @(posedge clk); #1;
        n_cmp++; if (over !== 1'b1 || wrong !== 1'b1) begin n_err++;
            $display("FAIL hold_first got over=%b wrong=%b exp over=1 wrong=1", over, wrong); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (over !== 1'b1 || wrong !== 1'b1) begin n_err++;
                $display("FAIL hold_cycle%0d got over=%b wrong=%b exp over=1 wrong=1", c, over, wrong); end
        end
        op_i = '0;
        @(posedge clk); #1;
        n_cmp++; if (over !== 1'b0 || wrong !== 1'b0) begin n_err++;
            $display("FAIL hold_release got over=%b wrong=%b exp 0 0", over, wrong); end
    endtask

    task automatic test_full_clear();
        run_op(3'b111, 0, 0, '0);
        n_cmp++; if (s_lat !== DEPTH || s_num !== 32'd0) begin n_err++;
            $display("FAIL clear1 got lat=%0d num=%0d exp lat=%0d num=0", s_lat, s_num, DEPTH); end
        for (int k = 1; k <= DEPTH; k++) begin
            run_op(3'b001, 0, 0, 65'({$urandom, $urandom, $urandom}));
            n_cmp++; if (s_id !== 6'(k) || s_lat !== k) begin n_err++;
                $display("FAIL fill%0d got id=%0d lat=%0d exp id=%0d lat=%0d", k, s_id, s_lat, k, k); end
        end
        run_op(3'b001, 0, 0, '0);
        n_cmp++; if (s_wrong !== 1'b1 || s_lat !== e_lat || s_num !== 32'(DEPTH) || s_id !== 6'(DEPTH)) begin n_err++;
            $display("FAIL new_full got wrong=%b lat=%0d num=%0d id=%0d exp wrong=1 lat=%0d num=%0d id=%0d",
                     s_wrong, s_lat, s_num, s_id, e_lat, DEPTH, DEPTH); end
`ifdef TICKET_STORE_FULL_EN
        n_cmp++; if (full_o !== 1'b1) begin n_err++;
            $display("FAIL full_flag got %b exp 1", full_o); end
`endif
        run_op(3'b111, 0, 0, '0);
        n_cmp++; if (s_lat !== DEPTH || s_num !== 32'd0 || s_wrong !== 1'b0 || full_o !== 1'b0) begin n_err++;
            $display("FAIL clear2 got lat=%0d num=%0d wrong=%b full=%b exp lat=%0d num=0 wrong=0 full=0",
                     s_lat, s_num, s_wrong, full_o, DEPTH); end
    endtask

    task automatic test_change();
        run_op(3'b001, 0, 0, '0);
        run_op(3'b011, 0, 6'd1, 65'h1_FFFF_FFFF_FFFF_FFFF);
        n_cmp++; if (s_wrong !== 1'b0 || s_lat !== 1) begin n_err++;
            $display("FAIL change1 got wrong=%b lat=%0d exp wrong=0 lat=1", s_wrong, s_lat); end
        run_op(3'b010, 0, 6'd1, '0);
        n_cmp++; if (s_data !== 65'h0_0FFF_FFFF_FFFF_FFFF) begin n_err++;
            $display("FAIL change_readback got %h exp %h", s_data, 65'h0_0FFF_FFFF_FFFF_FFFF); end
    endtask

    task automatic test_reset_mid_clear();
        for (int k = 0; k < 8; k++) run_op(3'b001, 0, 0, '0);
        op_i = 3'b111;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({over, wrong, num, id_o, data_o, full_o} !== '0) begin n_err++;
            $display("FAIL midclear_reset got over=%b wrong=%b num=%0d id=%0d data=%h full=%b exp all 0",
                     over, wrong, num, id_o, data_o, full_o); end
        op_i = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        run_op(3'b001, 0, 0, 65'd5);
        n_cmp++; if (s_id !== 6'd1 || s_lat !== 1 || s_num !== 32'd1) begin n_err++;
            $display("FAIL post_reset_new got id=%0d lat=%0d num=%0d exp id=1 lat=1 num=1", s_id, s_lat, s_num); end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] idx;
        logic [5:0]  id;
        int          r;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 32)      op = 3'b001;
            else if (r < 47) op = 3'b010;
            else if (r < 57) op = 3'b011;
            else if (r < 72) op = 3'b100;
            else if (r < 92) op = 3'b101;
            else if (r < 95) op = 3'b110;
            else             op = 3'b111;
            id  = 6'($urandom_range(0, DEPTH + 1));
            idx = 32'($urandom_range(0, m_cnt + 2));
            run_op(op, idx, id, 65'({$urandom, $urandom, $urandom}));
            n_cmp++;
            if (s_lat !== e_lat || s_wrong !== e_wrong || s_num !== 32'(m_cnt) ||
                s_id !== m_id_o || s_data !== m_data_o || s_over_after !== 1'b0 || s_wrong_after !== 1'b0) begin
                n_err++;
                $display("FAIL rand%0d op=%0d got lat=%0d wrong=%b num=%0d id=%0d data=%h over_after=%b exp lat=%0d wrong=%b num=%0d id=%0d data=%h over_after=0",
                         n, op, s_lat, s_wrong, s_num, s_id, s_data, s_over_after,
                         e_lat, e_wrong, m_cnt, m_id_o, m_data_o);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_new_read_delete();
        test_hold_done();
        test_full_clear();
        test_change();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
